// File: rtl/switch_light_arbiter.sv
// Round-robin owner of the 3-bit light bank, shared by four switch requesters.
// Define SWITCH_SYNC_EN to pass the switches through a 2-flop synchronizer first.
module switch_light_arbiter #(
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] switches,
    output logic [2:0] lights,
    output logic [3:0] grant,
    output logic       busy
);

    // Request/grant semantics: a request is a level on a switch bit; grant is the
    // registered acknowledgement, held at least HOLD_CYCLES cycles once raised.
    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        COOLDOWN
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       grant_nxt;
    logic [2:0]       lights_nxt;
    logic             busy_nxt;
    logic [3:0]       req;
    logic [1:0]       win;
    logic             others;

`ifdef SWITCH_SYNC_EN
    logic [3:0] sync1, sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switches;
            sync2 <= sync1;
        end
    end

    assign req = sync2;
`else
    assign req = switches;
`endif

    // Search from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) win = ptr + 2'(i);
        end
    end

    assign others = |(req & ~(4'b0001 << idx));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            idx    <= '0;
            cnt    <= '0;
            grant  <= '0;
            lights <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            idx    <= idx_nxt;
            cnt    <= cnt_nxt;
            grant  <= grant_nxt;
            lights <= lights_nxt;
            busy   <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        grant_nxt  = grant;
        lights_nxt = lights;
        busy_nxt   = busy;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt  = GRANT;
                    idx_nxt    = win;
                    cnt_nxt    = HOLD_INIT;
                    grant_nxt  = 4'b0001 << win;
                    lights_nxt = {1'b1, win};
                    busy_nxt   = 1'b1;
                end else begin
                    grant_nxt  = '0;
                    lights_nxt = '0;
                    busy_nxt   = 1'b0;
                end
            end
            GRANT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (!req[idx] || others) begin
                    // Release on drop or when anyone else is waiting; pointer moves past owner.
                    state_nxt  = COOLDOWN;
                    grant_nxt  = '0;
                    lights_nxt = '0;
                    busy_nxt   = 1'b1;
                    ptr_nxt    = idx + 2'd1;
                end
            end
            COOLDOWN: begin
                state_nxt  = IDLE;
                grant_nxt  = '0;
                lights_nxt = '0;
                busy_nxt   = 1'b0;
            end
            default: begin
                state_nxt  = IDLE;
                grant_nxt  = '0;
                lights_nxt = '0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_switch_light_arbiter.sv
// Self-checking bench for switch_light_arbiter: vector table, directed corner
// sequences, and randomized traffic against a behavioural ownership model.
module tb_switch_light_arbiter;

    localparam int HOLD  = 4;
    localparam int CNT_W = 4;
`ifdef SWITCH_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] switches = 4'b0000;
    logic [2:0] lights;
    logic [3:0] grant;
    logic       busy;

    always #5 clk = ~clk;

    switch_light_arbiter #(
        .HOLD_CYCLES(HOLD),
        .CNT_W      (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .switches(switches),
        .lights  (lights),
        .grant   (grant),
        .busy    (busy)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        string      name;
        bit         pre_rst;
        logic [3:0] sw;
        logic [2:0] lights;
        logic [3:0] grant;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    // ---------------- behavioural model ----------------
    int         m_owner;   // -1 when nobody owns the lights
    int         m_age;     // cycles the current owner has been visible
    int         m_dark;    // 1 during the single cooldown cycle
    int         m_ptr;
    logic [3:0] m_hist[$];

    function automatic void model_reset();
        m_owner = -1;
        m_age   = 0;
        m_dark  = 0;
        m_ptr   = 0;
        m_hist.delete();
        for (int i = 0; i < SYNC_DLY; i++) m_hist.push_back(4'b0000);
    endfunction

    function automatic void model_edge(input logic [3:0] sw_now);
        logic [3:0] sw;
        int         others;
        m_hist.push_back(sw_now);
        sw = m_hist.pop_front();
        if (m_owner >= 0) begin
            others = 0;
            for (int k = 0; k < 4; k++) if (k != m_owner && sw[k]) others++;
            if (m_age >= HOLD && (!sw[m_owner] || others > 0)) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_dark  = 1;
            end else begin
                m_age++;
            end
        end else if (m_dark == 1) begin
            m_dark = 0;
        end else if (sw != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && sw[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_age   = 1;
                end
            end
        end
    endfunction

    function automatic logic [7:0] model_out();
        logic [2:0] l;
        logic [3:0] g;
        logic       b;
        if (m_owner >= 0) begin
            l = {1'b1, 2'(m_owner)};
            g = 4'b0001 << m_owner;
        end else begin
            l = 3'b000;
            g = 4'b0000;
        end
        b = (m_owner >= 0) || (m_dark == 1);
        return {l, g, b};
    endfunction

    // ---------------- driver / checker tasks ----------------
    function automatic logic [7:0] outs();
        return {lights, grant, busy};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s @%0t: got lights=%b grant=%b busy=%b, expected lights=%b grant=%b busy=%b",
                     name, $time, got[7:5], got[4:1], got[0], exp[7:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic expect_out(input string name, input logic [2:0] l, input logic [3:0] g,
                              input logic b);
        check(name, outs(), {l, g, b});
    endtask

    task automatic tick(input bit use_model);
        logic [7:0] exp;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(switches);
        if (use_model) exp_q.push_back(model_out());
        #1;
        if (use_model) begin
            exp = exp_q.pop_front();
            check("random", outs(), exp);
        end
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic settle();
        switches = 4'b0000;
        repeat (12) tick(1'b0);
    endtask

    task automatic add_vec(input string name, input bit pre, input logic [3:0] sw,
                           input logic [2:0] l, input logic [3:0] g, input logic b);
        vec_t v;
        v.name    = name;
        v.pre_rst = pre;
        v.sw      = sw;
        v.lights  = l;
        v.grant   = g;
        v.busy    = b;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single pulse on requester 2: held 4 cycles, then 2 dark cycles.
        add_vec("pulse_grant",   1'b1, 4'b0100, 3'b110, 4'b0100, 1'b1);
        add_vec("pulse_hold1",   1'b0, 4'b0000, 3'b110, 4'b0100, 1'b1);
        add_vec("pulse_hold2",   1'b0, 4'b0000, 3'b110, 4'b0100, 1'b1);
        add_vec("pulse_hold3",   1'b0, 4'b0000, 3'b110, 4'b0100, 1'b1);
        add_vec("pulse_cool",    1'b0, 4'b0000, 3'b000, 4'b0000, 1'b1);
        add_vec("pulse_idle",    1'b0, 4'b0000, 3'b000, 4'b0000, 1'b0);
        add_vec("pulse_idle2",   1'b0, 4'b0000, 3'b000, 4'b0000, 1'b0);
        // Contention 1010 from ptr=0: idx1, idx3, idx1 with 2 dark cycles between.
        add_vec("cont_idx1",     1'b1, 4'b1010, 3'b101, 4'b0010, 1'b1);
        add_vec("cont_idx1_h1",  1'b0, 4'b1010, 3'b101, 4'b0010, 1'b1);
        add_vec("cont_idx1_h2",  1'b0, 4'b1010, 3'b101, 4'b0010, 1'b1);
        add_vec("cont_idx1_h3",  1'b0, 4'b1010, 3'b101, 4'b0010, 1'b1);
        add_vec("cont_cool1",    1'b0, 4'b1010, 3'b000, 4'b0000, 1'b1);
        add_vec("cont_idle1",    1'b0, 4'b1010, 3'b000, 4'b0000, 1'b0);
        add_vec("cont_idx3",     1'b0, 4'b1010, 3'b111, 4'b1000, 1'b1);
        add_vec("cont_idx3_h1",  1'b0, 4'b1010, 3'b111, 4'b1000, 1'b1);
        add_vec("cont_idx3_h2",  1'b0, 4'b1010, 3'b111, 4'b1000, 1'b1);
        add_vec("cont_idx3_h3",  1'b0, 4'b1010, 3'b111, 4'b1000, 1'b1);
        add_vec("cont_cool2",    1'b0, 4'b1010, 3'b000, 4'b0000, 1'b1);
        add_vec("cont_idle2",    1'b0, 4'b1010, 3'b000, 4'b0000, 1'b0);
        add_vec("cont_wrap_idx1",1'b0, 4'b1010, 3'b101, 4'b0010, 1'b1);
        add_vec("cont_drop_h1",  1'b0, 4'b0000, 3'b101, 4'b0010, 1'b1);
        add_vec("cont_drop_h2",  1'b0, 4'b0000, 3'b101, 4'b0010, 1'b1);
        add_vec("cont_drop_h3",  1'b0, 4'b0000, 3'b101, 4'b0010, 1'b1);
        add_vec("cont_drop_cool",1'b0, 4'b0000, 3'b000, 4'b0000, 1'b1);
        add_vec("cont_drop_idle",1'b0, 4'b0000, 3'b000, 4'b0000, 1'b0);

        // Reset asserted before any clock edge with every switch requesting.
        model_reset();
        switches = 4'b1111;
        #1;
        rst = 1'b1;
        #1;
        expect_out("reset_no_clk", 3'b000, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (SYNC_DLY) tick(1'b0);
        tick(1'b0);
        expect_out("first_grant_idx0", 3'b100, 4'b0001, 1'b1);
        settle();

`ifndef SWITCH_SYNC_EN
        foreach (vecs[i]) begin
            if (vecs[i].pre_rst) do_reset();
            switches = vecs[i].sw;
            tick(1'b0);
            expect_out(vecs[i].name, vecs[i].lights, vecs[i].grant, vecs[i].busy);
        end
        settle();

        // Sole requester keeps the lights indefinitely, releases on the edge after drop.
        switches = 4'b0001;
        tick(1'b0);
        expect_out("sole_grant", 3'b100, 4'b0001, 1'b1);
        for (int c = 1; c < 20; c++) begin
            tick(1'b0);
            expect_out("sole_hold", 3'b100, 4'b0001, 1'b1);
        end
        switches = 4'b0000;
        tick(1'b0);
        expect_out("sole_cool", 3'b000, 4'b0000, 1'b1);
        tick(1'b0);
        expect_out("sole_idle", 3'b000, 4'b0000, 1'b0);

        // Asynchronous reset two cycles into a grant, between edges.
        do_reset();
        switches = 4'b0100;
        tick(1'b0);
        expect_out("arst_grant", 3'b110, 4'b0100, 1'b1);
        tick(1'b0);
        tick(1'b0);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        expect_out("arst_clear", 3'b000, 4'b0000, 1'b0);
        switches = 4'b1100;
        @(posedge clk);
        #1;
        expect_out("arst_held", 3'b000, 4'b0000, 1'b0);
        rst = 1'b0;
        tick(1'b0);
        expect_out("arst_regrant_idx2", 3'b110, 4'b0100, 1'b1);
        settle();
`else
        // Synchronized input: a one-cycle glitch appears on the 3rd edge and is held 4 cycles.
        do_reset();
        switches = 4'b1000;
        tick(1'b0);
        switches = 4'b0000;
        expect_out("sync_edge1", 3'b000, 4'b0000, 1'b0);
        tick(1'b0);
        expect_out("sync_edge2", 3'b000, 4'b0000, 1'b0);
        tick(1'b0);
        expect_out("sync_edge3_grant", 3'b111, 4'b1000, 1'b1);
        for (int c = 1; c < HOLD; c++) begin
            tick(1'b0);
            expect_out("sync_hold", 3'b111, 4'b1000, 1'b1);
        end
        tick(1'b0);
        expect_out("sync_release", 3'b000, 4'b0000, 1'b1);
        settle();
`endif

        // Randomized traffic scored against the ownership model.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) switches = 4'($urandom_range(0, 15));
            tick(1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/switch_light_arbiter.md
Name: switch_light_arbiter

Overview:
- Round-robin arbiter that shares the 3-bit light bank among four switch requesters.
- Each switch is one requester. The winner owns the lights for a guaranteed minimum hold time.
- The lights show the owner's index plus a valid bit.
- Sits between the board switches and the lights; it replaces the direct combinational switch-to-light decode with a sequenced, fair owner.

Parameters:
HOLD_CYCLES, 8, minimum number of cycles a grant is held; legal range 1..(2^CNT_W - 1)
CNT_W, 4, width of the hold counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
switches  input  4  request vector; bit i = requester i
lights  output  3  {valid, grant_idx[1:0]}; 3'b000 when no owner
grant  output  4  one-hot grant, 4'b0000 when no owner
busy  output  1  high in GRANT or COOLDOWN

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Outputs are registered. Reset asserts immediately, without a clock edge: state=IDLE, ptr=0, cnt=0, lights=3'b000, grant=4'b0000, busy=0.
- FSM states: IDLE, GRANT, COOLDOWN.
- Round-robin pointer ptr[1:0]: the winner is the first set bit of switches searching ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- IDLE, switches==0: stay in IDLE; outputs stay 0.
- IDLE, switches!=0 at an edge: after that edge:
  - state=GRANT, grant=onehot(winner), lights={1,winner}, busy=1, cnt=HOLD_CYCLES-1.
  - Latency from request to grant is 1 cycle.
- GRANT, cnt>0: cnt decrements each edge. Grant is held regardless of switches, so grant is visible for at least HOLD_CYCLES cycles.
- GRANT, cnt==0: at each edge evaluate release:
  - Release when switches[idx]==0, OR any other switch bit is set (fairness preemption).
  - On release: state=COOLDOWN, grant=0, lights=0, busy=1, ptr=idx+1 (mod 4 wrap, 3→0).
  - Otherwise keep the grant indefinitely (sole requester); cnt stays 0.
- COOLDOWN: one cycle, then IDLE. Lights are dark for exactly 2 cycles between back-to-back grants (COOLDOWN plus IDLE).
- Switch changes during the hold are ignored except at the cnt==0 evaluation.
- Simultaneous requests are resolved solely by ptr. No requester waits more than 3 other grants.
- Reset mid-grant: outputs clear immediately and ptr returns to 0. After rst deasserts, the next grant follows the normal IDLE rules.
- No combinational path from switches to any output.

Optional Feature:
- Macro: SWITCH_SYNC_EN.
- Defined: switches pass through a 2-flop synchronizer (reset to 0) before the FSM. Request-to-grant latency becomes 3 cycles and all release decisions use the synchronized value.
- Undefined: switches feed the FSM directly; latency is 1 cycle.

Test Plan:
Bench uses HOLD_CYCLES=4, CNT_W=4, and SWITCH_SYNC_EN undefined unless noted.
1. Reset: rst=1 with switches=4'b1111, no clock -> lights=3'b000, grant=4'b0000, busy=0; after release, first grant goes to idx0 (lights=3'b100).
2. Single pulse: switches=4'b0100 for 1 cycle from IDLE -> next cycle grant=4'b0100, lights=3'b110, held exactly 4 cycles; then lights=3'b000 for 2 cycles with busy=1 then busy=0.
3. Contention: switches=4'b1010 held, ptr=0 -> idx1 (lights=3'b101) for 4 cycles, 2 dark cycles, idx3 (lights=3'b111) for 4 cycles, 2 dark cycles, idx1 again (wrap).
4. Sole requester: switches=4'b0001 held for 20 cycles -> grant=4'b0001, lights=3'b100 continuously; dropping the switch after 20 cycles -> COOLDOWN on the next edge.
5. Async reset mid-grant: assert rst 2 cycles into a grant of idx2, between clock edges -> all outputs 0 immediately; after release with switches=4'b1100 -> idx2 wins (ptr=0 search).
6. SWITCH_SYNC_EN defined: switches=4'b1000 from IDLE -> grant=4'b1000, lights=3'b111 on the 3rd edge after the switch changes; a 1-cycle glitch between edges is still held for 4 cycles once granted.
